// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the IF/LS single-port RAM arbiter.
package ram_port_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    // On a tie the port that did not win the previous accept goes next.
    function automatic logic rr_pick(input logic last_port);
        return ~last_port;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_ram_sp.sv
// Single-port synchronous RAM with a registered read port (1-cycle read latency).
module ram_sp
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch and
// load/store, with an LS lock for atomic read-modify-write sequences.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int LOCK_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              halt,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_valid,
    output logic              ls_ready,
    input  logic              ls_we,
    input  logic              ls_lock,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              locked
);

    localparam int              CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_lock_cnt, w_lock_cnt_nxt;
    logic              r_rr_last, w_rr_last_nxt;
    logic              r_if_pend, r_ls_pend;
    logic              w_if_grant, w_ls_grant, w_timeout;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_rdata;

    always_comb begin
        w_if_grant     = 1'b0;
        w_ls_grant     = 1'b0;
        w_timeout      = 1'b0;
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_rr_last_nxt  = r_rr_last;

        if (!halt) begin
            if (r_state == LOCKED) begin
                w_ls_grant = ls_valid;
            end else if (if_valid && ls_valid) begin
                if (rr_pick(r_rr_last) == PORT_LS) begin
                    w_ls_grant = 1'b1;
                end else begin
                    w_if_grant = 1'b1;
                end
            end else begin
                w_if_grant = if_valid;
                w_ls_grant = ls_valid;
            end
        end

        if (w_if_grant) begin
            w_rr_last_nxt = PORT_IF;
        end
        if (w_ls_grant) begin
            w_rr_last_nxt = PORT_LS;
        end

        // Timeout counts from lock entry; further locked accesses do not restart it.
        case (r_state)
            IDLE: begin
                if (w_ls_grant && ls_lock) begin
                    w_state_nxt    = LOCKED;
                    w_lock_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                if (!halt) begin
                    w_timeout      = (r_lock_cnt == CNT_LAST);
                    w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
                    if (w_timeout || (w_ls_grant && !ls_lock)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
            r_rr_last  <= PORT_LS;
            r_if_pend  <= 1'b0;
            r_ls_pend  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_rr_last  <= w_rr_last_nxt;
            r_if_pend  <= w_if_grant;
            r_ls_pend  <= w_ls_grant & ~ls_we;
        end
    end

    assign w_ram_we   = w_ls_grant & ls_we;
    assign w_ram_addr = w_ls_grant ? ls_addr : if_addr;

    ram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (CLK),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (ls_wdata),
        .rdata (w_ram_rdata)
    );

    assign if_ready = w_if_grant;
    assign ls_ready = w_ls_grant;
    assign locked   = (r_state == LOCKED);

    // A reset arriving while a read is in flight drops its response.
    assign if_rvalid = r_if_pend & ~RST;
    assign ls_rvalid = r_ls_pend & ~RST;
    assign if_rdata  = if_rvalid ? w_ram_rdata : '0;
    assign ls_rdata  = ls_rvalid ? w_ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table plus hand sequences, read data via scoreboard.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 8;
    localparam int LOCK_MAX = 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              halt = 1'b0;
    logic              if_valid = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              ls_valid = 1'b0;
    logic              ls_we = 1'b0;
    logic              ls_lock = 1'b0;
    logic [ADDR_W-1:0] ls_addr = '0;
    logic [DATA_W-1:0] ls_wdata = '0;
    logic              if_ready, if_rvalid, ls_ready, ls_rvalid, locked;
    logic [DATA_W-1:0] if_rdata, ls_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    ram_port_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .halt      (halt),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_addr   (if_addr),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_valid  (ls_valid),
        .ls_ready  (ls_ready),
        .ls_we     (ls_we),
        .ls_lock   (ls_lock),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .locked    (locked)
    );

    task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: memory model plus one-deep response queues per port.
    logic [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] q_if[$];
    logic [DATA_W-1:0] q_ls[$];
    logic              mon_exp_if, mon_exp_ls;

    always @(negedge CLK) begin
        mon_exp_if = (q_if.size() > 0) && !RST;
        mon_exp_ls = (q_ls.size() > 0) && !RST;
        check1("if_rvalid", if_rvalid, mon_exp_if);
        check1("ls_rvalid", ls_rvalid, mon_exp_ls);
        if (mon_exp_if) check1("if_rdata", if_rdata, q_if[0]);
        if (mon_exp_ls) check1("ls_rdata", ls_rdata, q_ls[0]);
        q_if.delete();
        q_ls.delete();
        if (if_valid && if_ready && !RST) q_if.push_back(model_mem[if_addr]);
        if (ls_valid && ls_ready) begin
            if (ls_we) model_mem[ls_addr] = ls_wdata;
            else if (!RST) q_ls.push_back(model_mem[ls_addr]);
        end
    end

    task automatic step(input logic rst_i, input logic halt_i,
                        input logic iv, input logic [7:0] ia,
                        input logic lv, input logic lwe, input logic llk,
                        input logic [7:0] la, input logic [31:0] wd,
                        input logic e_ir, input logic e_lr, input logic e_lk,
                        input int tag);
        @(posedge CLK);
        #1;
        RST      = rst_i;
        halt     = halt_i;
        if_valid = iv;
        if_addr  = ia;
        ls_valid = lv;
        ls_we    = lwe;
        ls_lock  = llk;
        ls_addr  = la;
        ls_wdata = wd;
        @(negedge CLK);
        check1($sformatf("step%0d if_ready", tag), if_ready, e_ir);
        check1($sformatf("step%0d ls_ready", tag), ls_ready, e_lr);
        check1($sformatf("step%0d locked", tag), locked, e_lk);
    endtask

    typedef struct {
        logic        rst, halt, iv;
        logic [7:0]  ia;
        logic        lv, lwe, llk;
        logic [7:0]  la;
        logic [31:0] wd;
        logic        e_ir, e_lr, e_lk;
        int          rep;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_i, input logic halt_i, input logic iv, input logic [7:0] ia,
                       input logic lv, input logic lwe, input logic llk, input logic [7:0] la,
                       input logic [31:0] wd, input logic e_ir, input logic e_lr, input logic e_lk,
                       input int rep);
        vec_t v;
        v.rst = rst_i; v.halt = halt_i; v.iv = iv; v.ia = ia;
        v.lv = lv; v.lwe = lwe; v.llk = llk; v.la = la; v.wd = wd;
        v.e_ir = e_ir; v.e_lr = e_lr; v.e_lk = e_lk; v.rep = rep;
        vecs.push_back(v);
    endtask

    int tag = 0;

    initial begin
        // reset, then preload through LS writes
        add(1,0, 0,0,   0,0,0,0,  0,            0,0,0, 2);
        add(0,0, 0,0,   1,1,0,3,  32'h00500093, 0,1,0, 1);
        add(0,0, 0,0,   1,1,0,10, 32'hA5A50010, 0,1,0, 1);
        add(0,0, 0,0,   1,1,0,11, 32'h11110011, 0,1,0, 1);
        add(0,0, 0,0,   1,1,0,12, 32'h22220012, 0,1,0, 1);
        add(0,0, 0,0,   0,0,0,0,  0,            0,0,0, 1);
        // single IF fetch
        add(0,0, 1,3,   0,0,0,0,  0,            1,0,0, 1);
        add(0,0, 0,0,   1,1,0,13, 32'h33330013, 0,1,0, 1);
        // both valid: alternate starting with IF
        add(0,0, 1,10,  1,0,0,13, 0,            1,0,0, 1);
        add(0,0, 1,11,  1,0,0,13, 0,            0,1,0, 1);
        add(0,0, 1,11,  1,0,0,3,  0,            1,0,0, 1);
        add(0,0, 1,12,  1,0,0,3,  0,            0,1,0, 1);
        add(0,0, 1,12,  1,0,0,10, 0,            1,0,0, 1);
        add(0,0, 1,12,  1,0,0,10, 0,            0,1,0, 1);
        // write then read same address back to back
        add(0,0, 0,0,   1,1,0,0,  32'd42,       0,1,0, 1);
        add(0,0, 0,0,   1,0,0,0,  0,            0,1,0, 1);
        add(0,0, 0,0,   0,0,0,0,  0,            0,0,0, 1);
        // locked RMW starves IF for three cycles
        add(0,0, 0,0,   1,0,1,11, 0,            0,1,0, 1);
        add(0,0, 1,10,  1,0,1,12, 0,            0,1,1, 2);
        add(0,0, 1,10,  1,0,0,13, 0,            0,1,1, 1);
        add(0,0, 1,10,  0,0,0,0,  0,            1,0,0, 1);

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                step(vecs[i].rst, vecs[i].halt, vecs[i].iv, vecs[i].ia,
                     vecs[i].lv, vecs[i].lwe, vecs[i].llk, vecs[i].la, vecs[i].wd,
                     vecs[i].e_ir, vecs[i].e_lr, vecs[i].e_lk, tag);
                if (i == 0 && r == 1) begin
                    check1("reset if_rdata", if_rdata, 32'h0);
                    check1("reset ls_rdata", ls_rdata, 32'h0);
                end
                tag++;
            end
        end

        // lock timeout with LS idle: locked for LOCK_MAX cycles
        step(0,0, 0,0,  1,0,1,12, 0, 0,1,0, tag++);
        for (int k = 0; k < LOCK_MAX; k++) step(0,0, 1,11, 0,0,0,0, 0, 0,0,1, tag++);
        step(0,0, 1,11, 0,0,0,0, 0, 1,0,0, tag++);

        // halt blocks both; in-flight IF read still returns
        step(0,1, 1,10, 1,0,0,12, 0, 0,0,0, tag++);
        step(0,0, 1,10, 1,0,0,12, 0, 0,1,0, tag++);

        // reset right after an accept suppresses the response
        step(0,0, 1,3,  0,0,0,0,  0, 1,0,0, tag++);
        step(1,0, 0,0,  0,0,0,0,  0, 0,0,0, tag++);
        check1("rst-after-accept if_rdata", if_rdata, 32'h0);
        step(0,0, 0,0,  0,0,0,0,  0, 0,0,0, tag++);

        // halt inside LOCKED freezes the timeout counter
        step(0,0, 0,0,  1,0,1,3,  0, 0,1,0, tag++);
        for (int k = 0; k < 3; k++) step(0,0, 1,10, 0,0,0,0,  0, 0,0,1, tag++);
        for (int k = 0; k < 3; k++) step(0,1, 1,10, 1,0,0,10, 0, 0,0,1, tag++);
        for (int k = 0; k < LOCK_MAX - 3; k++) step(0,0, 1,10, 0,0,0,0, 0, 0,0,1, tag++);
        step(0,0, 1,10, 0,0,0,0, 0, 1,0,0, tag++);

        // LS access on the timeout edge completes, FSM still leaves LOCKED
        step(0,0, 0,0,  1,0,1,10, 0, 0,1,0, tag++);
        for (int k = 0; k < LOCK_MAX - 1; k++) step(0,0, 0,0, 0,0,0,0, 0, 0,0,1, tag++);
        step(0,0, 0,0,  1,0,1,11, 0, 0,1,1, tag++);
        step(0,0, 1,12, 0,0,0,0,  0, 1,0,0, tag++);
        step(0,0, 0,0,  0,0,0,0,  0, 0,0,0, tag++);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
